// File: rtl/adc_scan_pkg.sv
// Purpose : shared types and width helpers for the round-robin ADC channel scanner.
// Latency : n/a (types and constant functions only).
// Backpr. : n/a.
// Contents: scan_state_t FSM encoding; ch_w/acc_w/cnt_w width functions.
package adc_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } scan_state_t;

    // Channel index width; a single-channel build still gets a 1-bit index.
    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Accumulator width: sum of 2**avg_log2 unsigned samples can never overflow.
    function automatic int acc_w(input int data_w, input int avg_log2);
        return data_w + avg_log2;
    endfunction

    // Sample counter width; pass-through averaging (avg_log2 = 0) keeps a 1-bit counter.
    function automatic int cnt_w(input int avg_log2);
        return (avg_log2 > 0) ? avg_log2 : 1;
    endfunction

endpackage

// File: rtl/adc_avg_accum.sv
// Purpose : accumulates 2**AVG_LOG2 unsigned samples and produces their mean.
// Latency : o_done/o_mean are combinational on the final i_load; state updates on the clock edge.
// Backpr. : none; the caller only pulses i_load for accepted samples.
// Ports   : i_clk, i_rst (sync, active-high), i_sample, i_load, i_clear -> o_done, o_mean.
module adc_avg_accum
    import adc_scan_pkg::*;
#(
    parameter int DATA_W   = 12,
    parameter int AVG_LOG2 = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_sample,
    input  logic              i_load,
    input  logic              i_clear,
    output logic              o_done,
    output logic [DATA_W-1:0] o_mean
);

    localparam int ACC_W = acc_w(DATA_W, AVG_LOG2);
    localparam int CNT_W = cnt_w(AVG_LOG2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [ACC_W-1:0] w_sum;

    // The mean includes the sample being loaded, so the result is ready on the final load.
    assign w_sum  = r_acc + ACC_W'(i_sample);
    assign o_done = i_load && (r_cnt == CNT_LAST);
    assign o_mean = DATA_W'(w_sum >> AVG_LOG2);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear || o_done) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/adc_channel_scanner.sv
// Purpose : round-robin MAX 10 ADC sequencer driver with per-channel averaging, result bank and LED view.
// Latency : result one cycle after final response; LED two cycles after bank write or disp_sel change.
// Backpr. : command_valid held until command_ready; missing responses skipped after TIMEOUT+1 cycles.
// Ports   : clock_clk, reset_sink_reset, enable; command_*/response_* sequencer handshake;
//           disp_sel -> led; result_valid/index/data; sticky err_timeout/err_mismatch/err_stray, clear_err.
module adc_channel_scanner
    import adc_scan_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int FIRST_CH       = 1,
    parameter int DATA_W         = 12,
    parameter int AVG_LOG2       = 2,
    parameter int DISP_W         = 8,
    parameter bit LED_ACTIVE_LOW = 1'b1,
    parameter int TIMEOUT        = 255,
    parameter int CH_W           = ch_w(NUM_CH)
) (
    input  logic              clock_clk,
    input  logic              reset_sink_reset,
    input  logic              enable,
    output logic              command_valid,
    output logic [4:0]        command_channel,
    input  logic              command_ready,
    input  logic              response_valid,
    input  logic [4:0]        response_channel,
    input  logic [DATA_W-1:0] response_data,
    input  logic [CH_W-1:0]   disp_sel,
    output logic [DISP_W-1:0] led,
    output logic              result_valid,
    output logic [CH_W-1:0]   result_index,
    output logic [DATA_W-1:0] result_data,
    output logic              err_timeout,
    output logic              err_mismatch,
    output logic              err_stray,
    input  logic              clear_err
);

    localparam int TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CH_W-1:0] IDX_LAST = CH_W'(NUM_CH - 1);

    scan_state_t       r_state;
    scan_state_t       w_state_nxt;
    logic [CH_W-1:0]   r_idx;
    logic [TO_W-1:0]   r_timer;
    logic [DATA_W-1:0] r_bank [NUM_CH];
    logic              r_res_vld;
    logic [CH_W-1:0]   r_res_idx;
    logic [DATA_W-1:0] r_res_dat;
    logic [DATA_W-1:0] r_disp;
    logic [DISP_W-1:0] r_led;
    logic              r_err_to;
    logic              r_err_mm;
    logic              r_err_st;

    logic              w_start;
    logic              w_hs;
    logic              w_rsp_match;
    logic              w_accept;
    logic              w_timeout;
    logic              w_mismatch;
    logic              w_stray;
    logic              w_acc_clear;
    logic              w_done;
    logic [DATA_W-1:0] w_mean;
    logic              w_bank_wr;
    logic              w_advance;
    logic [CH_W-1:0]   w_sel;
    logic [DISP_W-1:0] w_top;

    assign command_channel = 5'(FIRST_CH) + 5'(r_idx);
    assign command_valid   = (r_state == ISSUE);

    //----------------------------------------------------------------------
    // FSM
    //----------------------------------------------------------------------
    always_ff @(posedge clock_clk) begin
        if (reset_sink_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_hs        = 1'b0;
        w_accept    = 1'b0;
        w_timeout   = 1'b0;
        w_rsp_match = response_valid && (response_channel == command_channel);
        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_start     = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            // The command stays asserted until accepted, even if enable drops.
            ISSUE: begin
                if (command_ready) begin
                    w_hs        = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            // A matching response takes priority over a timer expiring the same cycle.
            WAIT: begin
                if (w_rsp_match) begin
                    w_accept    = 1'b1;
                    w_state_nxt = enable ? ISSUE : IDLE;
                end else if (r_timer == '0) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = enable ? ISSUE : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_stray    = response_valid && (r_state != WAIT);
    assign w_mismatch = response_valid && (r_state == WAIT) && !w_rsp_match;
    assign w_bank_wr  = w_accept && w_done;
    assign w_advance  = w_bank_wr || w_timeout;
    // Partial averages never survive a skipped channel or a stop.
    assign w_acc_clear = w_start || w_timeout || (w_accept && !enable);

    //----------------------------------------------------------------------
    // Averaging
    //----------------------------------------------------------------------
    adc_avg_accum #(
        .DATA_W   (DATA_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_accum (
        .i_clk    (clock_clk),
        .i_rst    (reset_sink_reset),
        .i_sample (response_data),
        .i_load   (w_accept),
        .i_clear  (w_acc_clear),
        .o_done   (w_done),
        .o_mean   (w_mean)
    );

    //----------------------------------------------------------------------
    // Index, timeout, bank, results, errors
    //----------------------------------------------------------------------
    always_ff @(posedge clock_clk) begin
        if (reset_sink_reset) begin
            r_idx     <= '0;
            r_timer   <= '0;
            r_res_vld <= 1'b0;
            r_res_idx <= '0;
            r_res_dat <= '0;
            r_err_to  <= 1'b0;
            r_err_mm  <= 1'b0;
            r_err_st  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_bank[i] <= '0;
            end
        end else begin
            if (w_start) begin
                r_idx <= '0;
            end else if (w_advance) begin
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end

            if (w_hs) begin
                r_timer <= TO_W'(TIMEOUT);
            end else if ((r_state == WAIT) && (r_timer != '0)) begin
                r_timer <= r_timer - 1'b1;
            end

            r_res_vld <= w_bank_wr;
            if (w_bank_wr) begin
                r_bank[r_idx] <= w_mean;
                r_res_idx     <= r_idx;
                r_res_dat     <= w_mean;
            end

            // A set event in the same cycle as clear_err wins.
            r_err_to <= w_timeout  || (r_err_to && !clear_err);
            r_err_mm <= w_mismatch || (r_err_mm && !clear_err);
            r_err_st <= w_stray    || (r_err_st && !clear_err);
        end
    end

    assign result_valid = r_res_vld;
    assign result_index = r_res_idx;
    assign result_data  = r_res_dat;
    assign err_timeout  = r_err_to;
    assign err_mismatch = r_err_mm;
    assign err_stray    = r_err_st;

    //----------------------------------------------------------------------
    // LED view: bank select stage, then formatted drive stage
    //----------------------------------------------------------------------
    assign w_sel = (int'(disp_sel) < NUM_CH) ? disp_sel : '0;

    generate
        if (DISP_W <= DATA_W) begin : g_top_slice
            assign w_top = r_disp[DATA_W-1 -: DISP_W];
        end else begin : g_top_pad
            assign w_top = {r_disp, {(DISP_W - DATA_W){1'b0}}};
        end
    endgenerate

    always_ff @(posedge clock_clk) begin
        if (reset_sink_reset) begin
            r_disp <= '0;
            r_led  <= LED_ACTIVE_LOW ? '1 : '0;
        end else begin
            r_disp <= r_bank[w_sel];
            r_led  <= LED_ACTIVE_LOW ? ~w_top : w_top;
        end
    end

    assign led = r_led;

endmodule

// File: tb/tb_adc_channel_scanner.sv
// Purpose : directed self-checking bench for adc_channel_scanner with default parameters.
// Latency : n/a.
// Backpr. : bench plays the sequencer, holding command_ready low when it wants to stall.
module tb_adc_channel_scanner;

    logic        clock_clk = 1'b0;
    logic        reset_sink_reset;
    logic        enable;
    logic        command_valid;
    logic [4:0]  command_channel;
    logic        command_ready;
    logic        response_valid;
    logic [4:0]  response_channel;
    logic [11:0] response_data;
    logic [1:0]  disp_sel;
    logic [7:0]  led;
    logic        result_valid;
    logic [1:0]  result_index;
    logic [11:0] result_data;
    logic        err_timeout;
    logic        err_mismatch;
    logic        err_stray;
    logic        clear_err;

    int n_chk  = 0;
    int n_fail = 0;

    always #25 clock_clk = ~clock_clk;

    adc_channel_scanner dut (
        .clock_clk        (clock_clk),
        .reset_sink_reset (reset_sink_reset),
        .enable           (enable),
        .command_valid    (command_valid),
        .command_channel  (command_channel),
        .command_ready    (command_ready),
        .response_valid   (response_valid),
        .response_channel (response_channel),
        .response_data    (response_data),
        .disp_sel         (disp_sel),
        .led              (led),
        .result_valid     (result_valid),
        .result_index     (result_index),
        .result_data      (result_data),
        .err_timeout      (err_timeout),
        .err_mismatch     (err_mismatch),
        .err_stray        (err_stray),
        .clear_err        (clear_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_clk);
        #1;
    endtask

    task automatic wait_cmd();
        int k;
        k = 0;
        while (command_valid !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk("cmd_wait", 32'(command_valid), 32'd1);
    endtask

    task automatic handshake(input logic [4:0] exp_ch);
        wait_cmd();
        chk("cmd_channel", 32'(command_channel), 32'(exp_ch));
        command_ready = 1'b1;
        tick();
        command_ready = 1'b0;
    endtask

    task automatic send_rsp(input logic [4:0] ch, input logic [11:0] data);
        response_valid   = 1'b1;
        response_channel = ch;
        response_data    = data;
        tick();
        response_valid   = 1'b0;
    endtask

    task automatic do_sample(input logic [4:0] ch, input logic [11:0] data);
        handshake(ch);
        send_rsp(ch, data);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_cmd_valid"}, 32'(command_valid), 32'd0);
        chk({tag, "_cmd_channel"}, 32'(command_channel), 32'd1);
        chk({tag, "_result_valid"}, 32'(result_valid), 32'd0);
        chk({tag, "_result_index"}, 32'(result_index), 32'd0);
        chk({tag, "_result_data"}, 32'(result_data), 32'd0);
        chk({tag, "_errors"}, 32'({err_timeout, err_mismatch, err_stray}), 32'd0);
        chk({tag, "_led"}, 32'(led), 32'hFF);
    endtask

    initial begin
        int bad;
        reset_sink_reset = 1'b1;
        enable           = 1'b0;
        command_ready    = 1'b0;
        response_valid   = 1'b0;
        response_channel = 5'd0;
        response_data    = 12'd0;
        disp_sel         = 2'd3;
        clear_err        = 1'b0;
        repeat (3) tick();
        reset_sink_reset = 1'b0;
        tick();
        check_reset_state("reset");

        // Four samples on ch1 average to 250.
        enable = 1'b1;
        do_sample(5'd1, 12'd100);
        do_sample(5'd1, 12'd200);
        do_sample(5'd1, 12'd300);
        chk("avg_no_early_result", 32'(result_valid), 32'd0);
        do_sample(5'd1, 12'd400);
        chk("avg_result_valid", 32'(result_valid), 32'd1);
        chk("avg_result_index", 32'(result_index), 32'd0);
        chk("avg_result_data", 32'(result_data), 32'd250);
        chk("avg_next_cmd_b2b", 32'(command_valid), 32'd1);
        chk("avg_next_cmd_ch", 32'(command_channel), 32'd2);
        tick();
        chk("avg_pulse_one_cycle", 32'(result_valid), 32'd0);

        // Constant 0xABC on the remaining channels; LED shows bank[3].
        for (int c = 2; c <= 4; c++) begin
            for (int s = 0; s < 4; s++) begin
                do_sample(5'(c), 12'hABC);
            end
        end
        chk("const_result_index", 32'(result_index), 32'd3);
        chk("const_result_data", 32'(result_data), 32'hABC);
        tick();
        chk("led_after_1cyc", 32'(led), 32'hFF);
        tick();
        chk("led_after_2cyc", 32'(led), 32'h54);
        disp_sel = 2'd0;
        tick();
        chk("led_sel_after_1cyc", 32'(led), 32'h54);
        tick();
        chk("led_sel_after_2cyc", 32'(led), 32'hF0);

        // Sequencer not ready for 50 cycles: command held steady.
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (command_valid !== 1'b1 || command_channel !== 5'd1 || result_valid !== 1'b0)
                bad++;
        end
        chk("ready_low_stall", 32'(bad), 32'd0);

        // No response after handshake: timeout on the 256th cycle.
        handshake(5'd1);
        repeat (255) tick();
        chk("timeout_not_yet", 32'(err_timeout), 32'd0);
        tick();
        chk("timeout_set", 32'(err_timeout), 32'd1);
        chk("timeout_idx_adv", 32'(command_channel), 32'd2);
        tick();
        tick();
        chk("timeout_bank_kept", 32'(led), 32'hF0);

        // Wrong-channel response is discarded and flagged.
        handshake(5'd2);
        send_rsp(5'd7, 12'hFFF);
        chk("mismatch_flag", 32'(err_mismatch), 32'd1);
        chk("mismatch_stays_wait", 32'(command_valid), 32'd0);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("clear_mismatch", 32'(err_mismatch), 32'd0);
        chk("clear_timeout", 32'(err_timeout), 32'd0);
        send_rsp(5'd2, 12'd10);
        do_sample(5'd2, 12'd20);
        do_sample(5'd2, 12'd30);
        do_sample(5'd2, 12'd41);
        chk("mismatch_result_index", 32'(result_index), 32'd1);
        chk("mismatch_result_data", 32'(result_data), 32'd25);

        // Stray response and clear_err together: set wins.
        wait_cmd();
        response_valid = 1'b1;
        clear_err      = 1'b1;
        tick();
        response_valid = 1'b0;
        clear_err      = 1'b0;
        chk("stray_set_wins", 32'(err_stray), 32'd1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("stray_cleared", 32'(err_stray), 32'd0);

        // Reset in WAIT with 2 of 4 samples accumulated on ch3.
        do_sample(5'd3, 12'd1);
        do_sample(5'd3, 12'd2);
        handshake(5'd3);
        reset_sink_reset = 1'b1;
        enable           = 1'b0;
        tick();
        tick();
        reset_sink_reset = 1'b0;
        check_reset_state("midrst");
        send_rsp(5'd3, 12'd5);
        chk("late_rsp_stray", 32'(err_stray), 32'd1);
        chk("late_rsp_idle", 32'(command_valid), 32'd0);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        enable = 1'b1;
        do_sample(5'd1, 12'd4);
        do_sample(5'd1, 12'd8);
        do_sample(5'd1, 12'd12);
        chk("fresh_no_early", 32'(result_valid), 32'd0);
        do_sample(5'd1, 12'd16);
        chk("fresh_result_index", 32'(result_index), 32'd0);
        chk("fresh_result_data", 32'(result_data), 32'd10);

        // Full-scale samples do not overflow the accumulator.
        for (int s = 0; s < 4; s++) begin
            do_sample(5'd2, 12'hFFF);
        end
        chk("fullscale_data", 32'(result_data), 32'hFFF);

        // Stop mid-average, then restart from index 0.
        do_sample(5'd3, 12'd100);
        handshake(5'd3);
        enable = 1'b0;
        send_rsp(5'd3, 12'd100);
        tick();
        chk("stop_no_cmd", 32'(command_valid), 32'd0);
        chk("stop_no_result", 32'(result_valid), 32'd0);
        enable = 1'b1;
        wait_cmd();
        chk("restart_ch", 32'(command_channel), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
